// File: rtl/matriz_serializador_pkg.sv
// matriz_pkg: shared constants, state type and slot layout for the packed matrix blocks.
package matriz_pkg;
  typedef enum logic {IDLE, SEND} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  // Column-major packing: element (i,j) lives in slot j*n+i.
  function automatic int slot(input int i, input int j, input int n);
    return j * n + i;
  endfunction
endpackage

// File: rtl/matriz_serializador_if.sv
// matriz_serializador_if: capture handshake plus serial element stream.
interface matriz_serializador_if #(parameter int EBit = 8, parameter int N = 2, parameter int P = 2);
  logic [P*N*EBit-1:0] in_result;
  logic                in_valid;
  logic                in_ready;
  logic [EBit-1:0]     out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  modport slave (input in_result, in_valid, out_ready, output in_ready, out_data, out_valid, out_last);
  modport master (output in_result, in_valid, out_ready, input in_ready, out_data, out_valid, out_last);
endinterface

// File: rtl/matriz_serializador_indice_cnt.sv
// matriz_indice_cnt: row-major 2-D row/col counter with clear, enable, wrap and last detect.
module matriz_indice_cnt #(parameter int N = 2, parameter int P = 2, parameter int IW = 1) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [IW-1:0] o_row,
  output logic [IW-1:0] o_col,
  output logic          o_last
);
  logic [IW-1:0] r_row, r_col;
  logic w_col_end, w_row_end;
  assign w_col_end = r_col == IW'(P - 1);
  assign w_row_end = r_row == IW'(N - 1);
  assign o_last = w_col_end & w_row_end;
  assign o_row = r_row;
  assign o_col = r_col;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_en) begin
      r_col <= w_col_end ? '0 : r_col + 1'b1;
      if (w_col_end) r_row <= w_row_end ? '0 : r_row + 1'b1;
    end
  end
endmodule

// File: rtl/matriz_serializador.sv
// matriz_serializador: captures a packed N x P result matrix and streams it row-major with a last flag.
// Defining MATRIZ_SER_INDICE_EN exposes the current row/col indices as out_row/out_col.
module matriz_serializador
  import matriz_pkg::*;
#(
  parameter int EBit = 8,
  parameter int N = 2,
  parameter int P = 2,
  localparam int IW = (clog2(N > P ? N : P) > 1) ? clog2(N > P ? N : P) : 1
) (
  input  logic clk,
  input  logic rst_n,
  matriz_serializador_if.slave bus
`ifdef MATRIZ_SER_INDICE_EN
  ,
  output logic [IW-1:0] out_row,
  output logic [IW-1:0] out_col
`endif
);
  localparam int SW = (clog2(N * P) > 1) ? clog2(N * P) : 1;
  state_t r_state, w_next;
  logic [P*N*EBit-1:0] r_cap;
  logic [IW-1:0] w_row, w_col;
  logic [EBit-1:0] w_elem [N*P];
  logic [SW-1:0] w_slot;
  logic w_last, w_cap, w_fire;
  assign w_cap = bus.in_valid & (r_state == IDLE);
  assign w_fire = bus.out_ready & (r_state == SEND);
  for (genvar s = 0; s < N * P; s++) begin : g_elem
    assign w_elem[s] = r_cap[s*EBit +: EBit];
  end
  assign w_slot = SW'(slot(int'(w_row), int'(w_col), N));
  matriz_indice_cnt #(.N(N), .P(P), .IW(IW)) u_cnt (
    .clk(clk), .rst_n(rst_n), .i_clr(w_cap), .i_en(w_fire),
    .o_row(w_row), .o_col(w_col), .o_last(w_last)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cap <= '0;
    end else begin
      r_state <= w_next;
      if (w_cap) r_cap <= bus.in_result;
    end
  end
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = bus.in_valid ? SEND : IDLE;
    else w_next = (bus.out_ready & w_last) ? IDLE : SEND;
  end
  always_comb begin
    bus.in_ready = r_state == IDLE;
    bus.out_valid = r_state == SEND;
    bus.out_last = (r_state == SEND) & w_last;
    bus.out_data = w_elem[w_slot];
  end
`ifdef MATRIZ_SER_INDICE_EN
  assign out_row = w_row;
  assign out_col = w_col;
`endif
endmodule
